// File: rtl/simeck_pkg.sv
// ============================================================================
// simeck_pkg : shared widths, FSM state and requester id types for Simeck32
// Revision   : 1.0
// ============================================================================
`default_nettype none

package simeck_pkg;

    localparam int unsigned BLK_W      = 32;
    localparam int unsigned KEY_W      = 16;
    localparam int unsigned DEF_ROUNDS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic id_t;

    // Simeck non-linear mixing: (x & rotl5(x)) ^ rotl1(x)
    function automatic logic [KEY_W-1:0] simeck_f(input logic [KEY_W-1:0] x);
        return (x & {x[10:0], x[15:11]}) ^ {x[14:0], x[15]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/simeck.sv
// ============================================================================
// simeck : one combinational Simeck32 round, out = {r ^ f(l) ^ key, l}
// Revision : 1.0
// ============================================================================
`default_nettype none

module simeck
    import simeck_pkg::*;
(
    input  logic [BLK_W-1:0] inp,
    input  logic [KEY_W-1:0] key,
    output logic [BLK_W-1:0] out
);

    logic [KEY_W-1:0] left;
    logic [KEY_W-1:0] right;

    assign left  = inp[BLK_W-1:KEY_W];
    assign right = inp[KEY_W-1:0];
    assign out   = {right ^ simeck_f(left) ^ key, left};

endmodule

`default_nettype wire

// File: rtl/simeck_rr_arb2.sv
// ============================================================================
// simeck_rr_arb2 : two-way round-robin grant, favours the requester that lost
// Revision       : 1.0
// ============================================================================
`default_nettype none

module simeck_rr_arb2
    import simeck_pkg::*;
(
    input  logic [1:0] valid,
    input  id_t        last_grant,
    output id_t        grant_id,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |valid;
        grant_id    = 1'b0;
        case (valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/simeck32_iter_ctrl.sv
// ============================================================================
// simeck32_iter_ctrl : iterative Simeck32 sequencer sharing one round core
//                      between two requesters, valid/ready response port
// Revision           : 1.0
// ============================================================================
`default_nettype none

module simeck32_iter_ctrl
    import simeck_pkg::*;
#(
    parameter int unsigned ROUNDS = DEF_ROUNDS,
    parameter int unsigned CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [BLK_W-1:0] req0_data,
    input  logic [KEY_W-1:0] req0_key,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [BLK_W-1:0] req1_data,
    input  logic [KEY_W-1:0] req1_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [BLK_W-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy
);

    if (ROUNDS < 1 || ROUNDS > 32) begin : g_bad_rounds
        $error("simeck32_iter_ctrl: ROUNDS must be in 1..32");
    end
    if ((2 ** CNT_W) < ROUNDS) begin : g_bad_cnt_w
        $error("simeck32_iter_ctrl: CNT_W too narrow for ROUNDS");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

    state_t           state;
    state_t           next_state;
    logic [BLK_W-1:0] blk_reg;
    logic [KEY_W-1:0] key_reg;
    id_t              id_reg;
    id_t              last_grant;
    logic [CNT_W-1:0] cnt;
    logic [BLK_W-1:0] round_out;
    id_t              grant_id;
    logic             grant_valid;
    logic             accept;

    simeck_rr_arb2 u_arb (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (last_grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    simeck u_round (
        .inp (blk_reg),
        .key (key_reg),
        .out (round_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    req0_ready = (grant_id == 1'b0);
                    req1_ready = (grant_id == 1'b1);
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_CNT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                // Returning to IDLE first leaves a one-cycle bubble before the next grant
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && grant_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_reg    <= '0;
            key_reg    <= '0;
            id_reg     <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else if (accept) begin
            blk_reg    <= grant_id ? req1_data : req0_data;
            key_reg    <= grant_id ? req1_key  : req0_key;
            id_reg     <= grant_id;
            last_grant <= grant_id;
            cnt        <= '0;
        end else if (state == RUN) begin
            blk_reg <= round_out;
            cnt     <= cnt + CNT_W'(1);
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_data  = rsp_valid ? blk_reg : '0;
    assign rsp_id    = rsp_valid ? id_reg : 1'b0;
    assign busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_simeck32_iter_ctrl.sv
// ============================================================================
// tb_simeck32_iter_ctrl : directed bench for the default build and a 1-round build
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_simeck32_iter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, rsp_ready;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [31:0] req0_data, req1_data, rsp_data;
    logic [15:0] req0_key, req1_key;

    logic        s_req0_valid, s_req1_valid, s_rsp_ready;
    logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_busy;
    logic [31:0] s_req0_data, s_req1_data, s_rsp_data;
    logic [15:0] s_req0_key, s_req1_key;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    simeck32_iter_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    simeck32_iter_ctrl #(.ROUNDS(1), .CNT_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_data(s_req0_data), .req0_key(s_req0_key),
        .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_data(s_req1_data), .req1_key(s_req1_key),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data), .rsp_id(s_rsp_id), .busy(s_busy)
    );

    // Reference cipher with the key held constant across rounds
    function automatic logic [31:0] ref_enc(input logic [31:0] pt, input logic [15:0] k, input int n);
        logic [15:0] x, y, t;
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < n; i++) begin
            t = x;
            x = y ^ (x & {x[10:0], x[15:11]}) ^ {x[14:0], x[15]} ^ k;
            y = t;
        end
        return {x, y};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    int          lat;
    int          g, r;
    logic        gid [4];
    logic        rid [4];
    logic [31:0] rdat[4];
    int          rcyc[4];

    initial begin
        rst_n = 1'b0;
        {req0_valid, req1_valid, rsp_ready} = '0;
        req0_data = '0; req1_data = '0; req0_key = '0; req1_key = '0;
        {s_req0_valid, s_req1_valid, s_rsp_ready} = '0;
        s_req0_data = '0; s_req1_data = '0; s_req0_key = '0; s_req1_key = '0;
        repeat (2) tick();

        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", {req1_ready, req0_ready}, 0);
        check("rst1_busy", s_busy, 0);
        rst_n = 1'b1;
        tick();

        // Both requesters contend from reset; expect 0,1,0,1
        req0_data = 32'h12345678; req0_key = 16'h0001;
        req1_data = 32'h9abcdef0; req1_key = 16'h0002;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        g = 0; r = 0;
        for (int c = 0; c < 400 && r < 4; c++) begin
            if (g < 4 && (req0_ready || req1_ready)) begin
                gid[g] = req1_ready;
                g++;
            end
            if (rsp_valid) begin
                rid[r] = rsp_id; rdat[r] = rsp_data; rcyc[r] = c;
                r++;
            end
            tick();
            if (g == 4) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
        end
        rsp_ready = 1'b0;
        check("rr_rsp_count", r, 4);
        for (int i = 0; i < 4; i++) begin
            check("rr_grant_id", gid[i], i % 2);
            check("rr_rsp_id", rid[i], i % 2);
            check("rr_rsp_data", rdat[i],
                  (i % 2) ? ref_enc(32'h9abcdef0, 16'h0002, 32) : ref_enc(32'h12345678, 16'h0001, 32));
        end
        // Spacing: 32 rounds, handshake cycle, one idle bubble
        for (int i = 1; i < 4; i++) check("rr_spacing", rcyc[i] - rcyc[i-1], 34);

        // Single request on req0
        req0_data = 32'h65656877; req0_key = 16'h1918; req0_valid = 1'b1;
        #1;
        check("t1_ready0", req0_ready, 1);
        check("t1_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("t1_busy", busy, 1);
        wait_rsp(lat);
        check("t1_latency", lat, 32);
        check("t1_data", rsp_data, ref_enc(32'h65656877, 16'h1918, 32));
        check("t1_id", rsp_id, 0);
        drain();
        check("t1_valid_drop", rsp_valid, 0);
        repeat (3) tick();
        check("t1_no_second_rsp", {busy, rsp_valid}, 0);

        // Inputs changed during RUN are ignored
        req0_data = 32'hdeadbeef; req0_key = 16'h1234; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        repeat (5) tick();
        req0_data = 32'h0badf00d; req0_key = 16'h4321; req0_valid = 1'b1;
        #1;
        check("t6_ready_in_run", req0_ready, 0);
        req0_valid = 1'b0;
        wait_rsp(lat);
        check("t6_data", rsp_data, ref_enc(32'hdeadbeef, 16'h1234, 32));
        drain();

        // Backpressure with a pending request on req0
        req1_data = 32'h01234567; req1_key = 16'ha5a5; req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        wait_rsp(lat);
        req0_data = 32'hcafef00d; req0_key = 16'h0f0f; req0_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_valid", rsp_valid, 1);
            check("t3_hold_data", rsp_data, ref_enc(32'h01234567, 16'ha5a5, 32));
            check("t3_hold_id", rsp_id, 1);
            check("t3_hold_ready", {req1_ready, req0_ready}, 0);
        end
        rsp_ready = 1'b1;
        #1;
        check("t3_no_accept_in_hs", req0_ready, 0);
        tick();
        rsp_ready = 1'b0;
        check("t3_idle", busy, 0);
        check("t3_ready_next", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        check("t3_accepted", busy, 1);
        wait_rsp(lat);
        check("t3_latency", lat, 32);
        check("t3_data", rsp_data, ref_enc(32'hcafef00d, 16'h0f0f, 32));
        drain();

        // Reset pulse at cnt=10 during RUN
        req0_data = 32'h65656877; req0_key = 16'h1918; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t4_rsp_valid", rsp_valid, 0);
        check("t4_rsp_data", rsp_data, 0);
        check("t4_rsp_id", rsp_id, 0);
        check("t4_busy", busy, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("t4_grant_after_rst", {req1_ready, req0_ready}, 2'b01);
        req1_valid = 1'b0;
        tick();
        req0_valid = 1'b0;
        wait_rsp(lat);
        check("t4_latency", lat, 32);
        check("t4_data", rsp_data, ref_enc(32'h65656877, 16'h1918, 32));
        drain();

        // One-round build
        s_req0_data = 32'h00000000; s_req0_key = 16'hffff; s_req0_valid = 1'b1;
        #1;
        check("t5_ready", s_req0_ready, 1);
        tick();
        s_req0_valid = 1'b0;
        check("t5_busy_run", {s_busy, s_rsp_valid}, 2'b10);
        tick();
        check("t5_valid", s_rsp_valid, 1);
        check("t5_data", s_rsp_data, 32'hffff0000);
        s_rsp_ready = 1'b1;
        tick();
        s_rsp_ready = 1'b0;
        s_req0_data = 32'h00010000; s_req0_key = 16'h0000; s_req0_valid = 1'b1;
        tick();
        s_req0_valid = 1'b0;
        tick();
        check("t5_data2", s_rsp_data, 32'h00020001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
